// File: rtl/coin_deposit.sv
// coin_deposit: money-entry front end of the vending machine.
// Accepts coins into a credit register (pmoney), lets the withdrawal side
// debit it through credit_take/take_amount, and pays the credit back one coin
// at a time on cancel.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   coin_valid/coin_type    coin presented (00=1, 01=2, 10=5, 11=10 units)
//   coin_ready              coins are taken only while idle
//   coin_accept/coin_reject one-cycle result of the previous coin handshake
//   cancel                  refund all credit
//   credit_take/take_amount debit request from the withdrawal side
//   take_error              one-cycle pulse: previous take was refused
//   refund_valid/refund_coin/refund_ready  refund coin handshake
//   pmoney                  registered credit
//   sevensegment            hex digit of pmoney[3:0], {g,f,e,d,c,b,a}, active-high
//   redlight                last coin was rejected
//   audit_total             (only with DEPOSIT_AUDIT_EN) saturating sum of accepted coins
//
// Build option: define DEPOSIT_AUDIT_EN to add the audit_total counter/port.
//
// state  | meaning
// IDLE   | taking coins and debits
// REFUND | paying credit back, largest coin first

module coin_deposit #(
  parameter int CREDIT_W   = 4,
  parameter int MAX_CREDIT = 15
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  output logic                coin_ready,
  output logic                coin_accept,
  output logic                coin_reject,
  input  logic                cancel,
  input  logic                credit_take,
  input  logic [CREDIT_W-1:0] take_amount,
  output logic                take_error,
  output logic                refund_valid,
  output logic [1:0]          refund_coin,
  input  logic                refund_ready,
  output logic [CREDIT_W-1:0] pmoney,
  output logic [6:0]          sevensegment,
`ifdef DEPOSIT_AUDIT_EN
  output logic [15:0]         audit_total,
`endif
  output logic                redlight
);

  localparam int SUM_W = CREDIT_W + 1;

  typedef enum logic {IDLE, REFUND} state_t;

  state_t              state, state_nxt;
  logic [SUM_W-1:0]    pm_ext, coin_val, base, coin_sum, refund_val, refund_left;
  logic                coin_hs, cancel_go, take_legal, coin_fits;
  logic [CREDIT_W-1:0] pmoney_nxt;
  logic                accept_nxt, reject_nxt, take_err_nxt;
  logic [3:0]          digit;

  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // credit arithmetic, all in CREDIT_W+1 bits
  always_comb begin
    pm_ext = {1'b0, pmoney};
    case (coin_type)
      2'b00:   coin_val = SUM_W'(1);
      2'b01:   coin_val = SUM_W'(2);
      2'b10:   coin_val = SUM_W'(5);
      default: coin_val = SUM_W'(10);
    endcase
    // a cancel with no credit has no effect at all
    cancel_go  = cancel && (pmoney != '0);
    take_legal = credit_take && (take_amount <= pmoney) && !cancel_go;
    base       = take_legal ? (pm_ext - {1'b0, take_amount}) : pm_ext;
    coin_sum   = base + coin_val;
    coin_hs    = coin_valid && (state == IDLE);
    coin_fits  = coin_hs && !cancel_go && (coin_sum <= SUM_W'(MAX_CREDIT));
    case (refund_coin)
      2'b11:   refund_val = SUM_W'(10);
      2'b10:   refund_val = SUM_W'(5);
      2'b01:   refund_val = SUM_W'(2);
      default: refund_val = SUM_W'(1);
    endcase
    refund_left = pm_ext - refund_val;
  end

  // next state and next datapath values
  always_comb begin
    state_nxt    = state;
    pmoney_nxt   = pmoney;
    accept_nxt   = 1'b0;
    reject_nxt   = 1'b0;
    take_err_nxt = credit_take;
    case (state)
      IDLE: begin
        accept_nxt   = coin_fits;
        reject_nxt   = coin_hs && !coin_fits;
        take_err_nxt = credit_take && !take_legal;
        if (cancel_go)      state_nxt  = REFUND;
        else if (coin_fits) pmoney_nxt = coin_sum[CREDIT_W-1:0];
        else                pmoney_nxt = base[CREDIT_W-1:0];
      end
      REFUND: begin
        if (refund_ready) begin
          pmoney_nxt = refund_left[CREDIT_W-1:0];
          if (refund_left == '0) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pmoney      <= '0;
      coin_accept <= 1'b0;
      coin_reject <= 1'b0;
      take_error  <= 1'b0;
      redlight    <= 1'b0;
    end else begin
      pmoney      <= pmoney_nxt;
      coin_accept <= accept_nxt;
      coin_reject <= reject_nxt;
      take_error  <= take_err_nxt;
      if (accept_nxt)      redlight <= 1'b0;
      else if (reject_nxt) redlight <= 1'b1;
    end
  end

`ifdef DEPOSIT_AUDIT_EN
  logic [16:0] audit_sum;
  assign audit_sum = {1'b0, audit_total} + 17'(coin_val);

  always_ff @(posedge clock) begin
    if (reset)          audit_total <= '0;
    else if (coin_fits) audit_total <= audit_sum[16] ? 16'hFFFF : audit_sum[15:0];
  end
`endif

  // outputs
  always_comb begin
    coin_ready   = (state == IDLE);
    refund_valid = (state == REFUND);
    if (pmoney >= CREDIT_W'(10))     refund_coin = 2'b11;
    else if (pmoney >= CREDIT_W'(5)) refund_coin = 2'b10;
    else if (pmoney >= CREDIT_W'(2)) refund_coin = 2'b01;
    else                             refund_coin = 2'b00;
    digit = 4'(pmoney);
    case (digit)
      4'h0: sevensegment = 7'b0111111;
      4'h1: sevensegment = 7'b0000110;
      4'h2: sevensegment = 7'b1011011;
      4'h3: sevensegment = 7'b1001111;
      4'h4: sevensegment = 7'b1100110;
      4'h5: sevensegment = 7'b1101101;
      4'h6: sevensegment = 7'b1111101;
      4'h7: sevensegment = 7'b0000111;
      4'h8: sevensegment = 7'b1111111;
      4'h9: sevensegment = 7'b1101111;
      4'hA: sevensegment = 7'b1110111;
      4'hB: sevensegment = 7'b1111100;
      4'hC: sevensegment = 7'b0111001;
      4'hD: sevensegment = 7'b1011110;
      4'hE: sevensegment = 7'b1111001;
      default: sevensegment = 7'b1110001;
    endcase
  end

endmodule
